// File: rtl/gshare_predictor_pkg.sv
// Shared types and defaults for the gshare direction predictor.
// Covers FSM states, the classic 2-bit counter encoding and the counter reset value.
package gshare_predictor_pkg;

  typedef enum logic {
    INIT,
    READY
  } pred_state_t;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cntr_pattern_t;

  localparam int DEF_GHR_SIZE           = 8;
  localparam int DEF_COUNTER_TABLE_BITS = 10;
  localparam int DEF_COUNTER_BITS       = 2;

  // Weakly-not-taken value for any counter width; a 1-bit counter starts at 0.
  function automatic int counterInit(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_table.sv
// Saturating counter array for the gshare predictor.
// One combinational read port; one write port that either loads the init value or steps a counter.
module sat_counter_table
  import gshare_predictor_pkg::*;
#(
  parameter int ADDR_BITS = DEF_COUNTER_TABLE_BITS,
  parameter int CNT_BITS  = DEF_COUNTER_BITS
) (
  input  logic                 clk_i,
  input  logic [ADDR_BITS-1:0] rd_idx_i,
  output logic [CNT_BITS-1:0]  rd_cnt_o,
  input  logic                 wr_en_i,
  input  logic                 wr_init_i,
  input  logic [ADDR_BITS-1:0] wr_idx_i,
  input  logic                 wr_taken_i
);

  localparam logic [CNT_BITS-1:0] INIT_VAL = CNT_BITS'(counterInit(CNT_BITS));

  logic [CNT_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [CNT_BITS-1:0] wr_cur;
  logic [CNT_BITS-1:0] wr_d;

  assign rd_cnt_o = mem_q[rd_idx_i];

  // Step toward the outcome, holding at either end of the range.
  always_comb begin
    wr_cur = mem_q[wr_idx_i];
    wr_d   = wr_cur;
    if (wr_init_i) begin
      wr_d = INIT_VAL;
    end else if (wr_taken_i) begin
      if (wr_cur != '1) wr_d = wr_cur + 1'b1;
    end else begin
      if (wr_cur != '0) wr_d = wr_cur - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_d;
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: speculative global history, counter-table lookup,
// post-reset table sweep and history recovery on mispredict.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int TABLE_BITS   = DEF_COUNTER_TABLE_BITS,
  parameter int GHR_SIZE     = DEF_GHR_SIZE,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int PC_LSB       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid_i,
  input  logic [31:0]         pred_pc_i,
  output logic                pred_ready_o,
  output logic                pred_taken_o,
  output logic [GHR_SIZE-1:0] pred_ghr_o,
  input  logic                upd_valid_i,
  input  logic [31:0]         upd_pc_i,
  input  logic [GHR_SIZE-1:0] upd_ghr_i,
  input  logic                upd_taken_i,
  input  logic                upd_mispredict_i
);

  localparam int FIT_BITS = (GHR_SIZE > TABLE_BITS) ? TABLE_BITS : GHR_SIZE;

  pred_state_t             state_q;
  logic [TABLE_BITS-1:0]   init_idx_q;
  logic [GHR_SIZE-1:0]     ghr_q;
  logic [GHR_SIZE-1:0]     ghr_d;
  logic                    ready;
  logic [TABLE_BITS-1:0]   pred_idx;
  logic [TABLE_BITS-1:0]   upd_idx;
  logic [COUNTER_BITS-1:0] rd_cnt;
  logic                    wr_en;
  logic                    wr_init;
  logic [TABLE_BITS-1:0]   wr_idx;
  logic                    unused_bits;

  function automatic logic [TABLE_BITS-1:0] calcIdx(input logic [31:0] pc,
                                                    input logic [GHR_SIZE-1:0] ghr);
    logic [TABLE_BITS-1:0] fit;
    fit = '0;
    fit[FIT_BITS-1:0] = ghr[FIT_BITS-1:0];
    return pc[PC_LSB +: TABLE_BITS] ^ fit;
  endfunction

  assign ready        = (state_q == READY) && !rst;
  assign pred_idx     = calcIdx(pred_pc_i, ghr_q);
  assign upd_idx      = calcIdx(upd_pc_i, upd_ghr_i);
  assign pred_ready_o = ready;
  assign pred_taken_o = ready & rd_cnt[COUNTER_BITS-1];
  assign pred_ghr_o   = ready ? ghr_q : '0;
  assign unused_bits  = ^{pred_pc_i, upd_pc_i, upd_ghr_i, rd_cnt};

  // The sweep owns the write port until READY; afterwards resolved branches use it.
  assign wr_en   = !rst && ((state_q == INIT) || upd_valid_i);
  assign wr_init = (state_q == INIT);
  assign wr_idx  = (state_q == INIT) ? init_idx_q : upd_idx;

  // Recovery wins over the speculative shift of a prediction made in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i && upd_mispredict_i) begin
      ghr_d = {upd_ghr_i[GHR_SIZE-2:0], upd_taken_i};
    end else if (pred_valid_i) begin
      ghr_d = {ghr_q[GHR_SIZE-2:0], pred_taken_o};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ghr_q      <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == '1) state_q <= READY;
        end
        READY: ghr_q <= ghr_d;
      endcase
    end
  end

  sat_counter_table #(
    .ADDR_BITS(TABLE_BITS),
    .CNT_BITS (COUNTER_BITS)
  ) u_table (
    .clk_i     (clk),
    .rd_idx_i  (pred_idx),
    .rd_cnt_o  (rd_cnt),
    .wr_en_i   (wr_en),
    .wr_init_i (wr_init),
    .wr_idx_i  (wr_idx),
    .wr_taken_i(upd_taken_i)
  );

endmodule
